// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Groups the writeback handshakes, the reservation handshake and the
//   register-file write triple used by regfile_write_arbiter.
//
//   Requesters / issue stage (master drives):
//     AluValid, AluRD, AluData   ALU writeback request
//     MemValid, MemRD, MemData   load writeback request
//     ResValid, ResRD            destination reservation
//   Arbiter (slave drives):
//     AluReady, MemReady         request accepted this cycle
//     ResReady                   reservation accepted (register not busy)
//     BusyMask                   registers with a write outstanding
//     RegWrite, RD, WriteData    registered register-file write port
//     ErrUnreserved              sticky: accepted write to a non-busy register
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                AluValid;
  logic [ADDR_W-1:0]   AluRD;
  logic [DATA_W-1:0]   AluData;
  logic                AluReady;

  logic                MemValid;
  logic [ADDR_W-1:0]   MemRD;
  logic [DATA_W-1:0]   MemData;
  logic                MemReady;

  logic                ResValid;
  logic [ADDR_W-1:0]   ResRD;
  logic                ResReady;

  logic [NUM_REGS-1:0] BusyMask;
  logic                RegWrite;
  logic [ADDR_W-1:0]   RD;
  logic [DATA_W-1:0]   WriteData;
  logic                ErrUnreserved;

  modport master (
    output AluValid, AluRD, AluData,
    output MemValid, MemRD, MemData,
    output ResValid, ResRD,
    input  AluReady, MemReady, ResReady,
    input  BusyMask, RegWrite, RD, WriteData, ErrUnreserved
  );

  modport slave (
    input  AluValid, AluRD, AluData,
    input  MemValid, MemRD, MemData,
    input  ResValid, ResRD,
    output AluReady, MemReady, ResReady,
    output BusyMask, RegWrite, RD, WriteData, ErrUnreserved
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between ALU writebacks and
//   memory-load writebacks. At most one write is accepted per cycle, with
//   round-robin arbitration on conflict. A busy-register scoreboard lets the
//   issue stage stall on RAW/WAW hazards.
//
//   Ports:
//     Clock     rising-edge system clock
//     Reset_n   asynchronous active-low reset
//     bus       regfile_write_arbiter_if.slave (handshakes, scoreboard,
//               register-file write triple, error flag)
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input logic                    Clock,
  input logic                    Reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Round-robin pointer: which source was granted most recently.
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } ptr_e;

  ptr_e                last_q, last_d;
  logic                regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  logic                grant_alu;
  logic                grant_mem;
  logic                grant_any;
  logic                res_ready;
  logic                res_fire;
  logic [ADDR_W-1:0]   win_rd;
  logic [DATA_W-1:0]   win_data;

  // Arbitration. Readies are forced low while reset is asserted so no
  // handshake can be observed during reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (Reset_n) begin
      if (bus.AluValid && bus.MemValid) begin
        grant_alu = (last_q == PTR_MEM);
        grant_mem = (last_q == PTR_ALU);
      end else begin
        grant_alu = bus.AluValid;
        grant_mem = bus.MemValid;
      end
    end
  end

  assign grant_any = grant_alu | grant_mem;
  assign win_rd    = grant_mem ? bus.MemRD   : bus.AluRD;
  assign win_data  = grant_mem ? bus.MemData : bus.AluData;

  // Reservation readiness depends only on the scoreboard, not on ResValid.
  assign res_ready = Reset_n & ~busy_q[bus.ResRD];
  assign res_fire  = bus.ResValid & res_ready;

  // Next-state logic.
  always_comb begin
    last_d     = last_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    err_d      = err_q;

    if (grant_alu) begin
      last_d = PTR_ALU;
    end else if (grant_mem) begin
      last_d = PTR_MEM;
    end

    if (grant_any) begin
      regwrite_d = 1'b1;
      rd_d       = win_rd;
      wdata_d    = win_data;
      if (!busy_q[win_rd]) begin
        err_d = 1'b1;
      end
    end

    // The bit clears at the edge where the register file captures the
    // write; a reservation at that same edge is applied afterwards so it wins.
    if (regwrite_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (res_fire) begin
      busy_d[bus.ResRD] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q     <= PTR_MEM;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.AluReady      = grant_alu;
  assign bus.MemReady      = grant_mem;
  assign bus.ResReady      = res_ready;
  assign bus.BusyMask      = busy_q;
  assign bus.RegWrite      = regwrite_q;
  assign bus.RD            = rd_q;
  assign bus.WriteData     = wdata_q;
  assign bus.ErrUnreserved = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter: reset, round-robin conflict,
//   stall hold, single-source write, WAW stall, unreserved-write error with
//   same-edge set/clear, and reset in the middle of a write.
module tb_regfile_write_arbiter;
  logic Clock;
  logic Reset_n;
  int   checks   = 0;
  int   failures = 0;

  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(2)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(2)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n      = 1'b0;
    bus.AluValid = 1'b1;
    bus.AluRD    = '0;
    bus.AluData  = '0;
    bus.MemValid = 1'b0;
    bus.MemRD    = '0;
    bus.MemData  = '0;
    bus.ResValid = 1'b1;
    bus.ResRD    = '0;
    #3;
    check("rst_alu_ready", bus.AluReady, 0);
    check("rst_res_ready", bus.ResReady, 0);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_busy", bus.BusyMask, 0);
    check("rst_err", bus.ErrUnreserved, 0);

    tick;
    Reset_n      = 1'b1;
    bus.AluValid = 1'b0;
    bus.ResValid = 1'b0;

    // Reserve all four registers.
    for (int r = 0; r < 4; r++) begin
      bus.ResValid = 1'b1;
      bus.ResRD    = 2'(r);
      #1 check("res_all_ready", bus.ResReady, 1);
      tick;
    end
    bus.ResValid = 1'b0;
    check("res_all_busy", bus.BusyMask, 4'hF);

    // Conflict: both valid for 4 cycles, ALU wins first after reset.
    bus.AluValid = 1'b1; bus.AluRD = 2'd1; bus.AluData = 16'hA001;
    bus.MemValid = 1'b1; bus.MemRD = 2'd3; bus.MemData = 16'hB003;
    #1;
    check("c0_alu_ready", bus.AluReady, 1);
    check("c0_mem_ready", bus.MemReady, 0);
    tick;
    check("c0_regwrite", bus.RegWrite, 1);
    check("c0_rd", bus.RD, 1);
    check("c0_wdata", bus.WriteData, 16'hA001);
    bus.AluRD = 2'd2; bus.AluData = 16'hA002;
    #1;
    check("c1_alu_ready", bus.AluReady, 0);
    check("c1_mem_ready", bus.MemReady, 1);
    tick;
    check("c1_rd", bus.RD, 3);
    check("c1_wdata", bus.WriteData, 16'hB003);
    check("c1_busy", bus.BusyMask, 4'hD);
    bus.MemRD = 2'd0; bus.MemData = 16'hB000;
    #1;
    check("c2_alu_ready", bus.AluReady, 1);
    check("c2_mem_ready", bus.MemReady, 0);
    tick;
    check("c2_rd", bus.RD, 2);
    check("c2_wdata", bus.WriteData, 16'hA002);
    check("c2_busy", bus.BusyMask, 4'h5);
    bus.AluData = 16'hA0FF;
    #1;
    check("c3_alu_ready", bus.AluReady, 0);
    check("c3_mem_ready", bus.MemReady, 1);
    tick;
    check("c3_rd", bus.RD, 0);
    check("c3_wdata", bus.WriteData, 16'hB000);
    check("c3_busy", bus.BusyMask, 4'h1);
    bus.AluValid = 1'b0;
    bus.MemValid = 1'b0;
    tick;
    check("idle_regwrite", bus.RegWrite, 0);
    check("idle_busy", bus.BusyMask, 4'h0);
    check("idle_wdata_hold", bus.WriteData, 16'hB000);
    check("idle_err", bus.ErrUnreserved, 0);

    // Stall hold: last grant was MEM, so ALU wins once, then MEM.
    bus.ResValid = 1'b1; bus.ResRD = 2'd1;
    tick;
    bus.ResRD = 2'd3;
    tick;
    bus.ResValid = 1'b0;
    check("sh_busy", bus.BusyMask, 4'hA);
    bus.MemValid = 1'b1; bus.MemRD = 2'd3; bus.MemData = 16'hC0DE;
    bus.AluValid = 1'b1; bus.AluRD = 2'd1; bus.AluData = 16'h1111;
    #1;
    check("sh0_alu_ready", bus.AluReady, 1);
    check("sh0_mem_ready", bus.MemReady, 0);
    tick;
    check("sh0_wdata", bus.WriteData, 16'h1111);
    bus.AluValid = 1'b0;
    #1;
    check("sh1_mem_ready", bus.MemReady, 1);
    tick;
    check("sh1_rd", bus.RD, 3);
    check("sh1_wdata", bus.WriteData, 16'hC0DE);
    bus.MemValid = 1'b0;
    tick;
    check("sh2_no_dup", bus.RegWrite, 0);
    check("sh2_busy", bus.BusyMask, 4'h0);

    // Single source: reserve r2, ALU writes BEEF.
    bus.ResValid = 1'b1; bus.ResRD = 2'd2;
    #1 check("ss_res_ready", bus.ResReady, 1);
    tick;
    bus.ResValid = 1'b0;
    check("ss_busy_set", bus.BusyMask, 4'h4);
    bus.AluValid = 1'b1; bus.AluRD = 2'd2; bus.AluData = 16'hBEEF;
    #1;
    check("ss_alu_ready", bus.AluReady, 1);
    check("ss_mem_ready", bus.MemReady, 0);
    tick;
    bus.AluValid = 1'b0;
    check("ss_regwrite", bus.RegWrite, 1);
    check("ss_rd", bus.RD, 2);
    check("ss_wdata", bus.WriteData, 16'hBEEF);
    check("ss_busy_inflight", bus.BusyMask, 4'h4);
    tick;
    check("ss_regwrite_low", bus.RegWrite, 0);
    check("ss_busy_clear", bus.BusyMask, 4'h0);
    check("ss_rd_hold", bus.RD, 2);

    // WAW stall on r1.
    bus.ResValid = 1'b1; bus.ResRD = 2'd1;
    #1 check("waw_first_ready", bus.ResReady, 1);
    tick;
    check("waw_busy", bus.BusyMask, 4'h2);
    check("waw_stall", bus.ResReady, 0);
    tick;
    check("waw_busy_hold", bus.BusyMask, 4'h2);
    bus.ResValid = 1'b0;

    // Unreserved MEM write to r0, then reserve r0 at the clearing edge.
    bus.MemValid = 1'b1; bus.MemRD = 2'd0; bus.MemData = 16'hDEAD;
    #1 check("err_mem_ready", bus.MemReady, 1);
    tick;
    bus.MemValid = 1'b0;
    check("err_regwrite", bus.RegWrite, 1);
    check("err_wdata", bus.WriteData, 16'hDEAD);
    check("err_flag", bus.ErrUnreserved, 1);
    bus.ResValid = 1'b1; bus.ResRD = 2'd0;
    #1 check("setwin_res_ready", bus.ResReady, 1);
    tick;
    bus.ResValid = 1'b0;
    check("setwin_busy", bus.BusyMask, 4'h3);
    check("err_sticky", bus.ErrUnreserved, 1);

    // Reset mid-stream with a write in flight.
    bus.AluValid = 1'b1; bus.AluRD = 2'd1; bus.AluData = 16'h5A5A;
    tick;
    check("mr_regwrite", bus.RegWrite, 1);
    bus.AluRD = 2'd0; bus.AluData = 16'hAAAA;
    bus.MemValid = 1'b1; bus.MemRD = 2'd1; bus.MemData = 16'hBBBB;
    #2 Reset_n = 1'b0;
    #1;
    check("mr_regwrite_drop", bus.RegWrite, 0);
    check("mr_rd", bus.RD, 0);
    check("mr_wdata", bus.WriteData, 0);
    check("mr_busy", bus.BusyMask, 0);
    check("mr_err", bus.ErrUnreserved, 0);
    check("mr_alu_ready", bus.AluReady, 0);
    check("mr_mem_ready", bus.MemReady, 0);
    tick;
    Reset_n = 1'b1;
    #1;
    check("post_rst_alu_ready", bus.AluReady, 1);
    check("post_rst_mem_ready", bus.MemReady, 0);
    tick;
    check("post_rst_rd", bus.RD, 0);
    check("post_rst_wdata", bus.WriteData, 16'hAAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
